// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle core's unified
// instruction/data port. It accepts one access per request/ready handshake
// and inserts WAIT_STATES cycles before answering. Stores are byte/half/word
// with lane merging; loads are sign- or zero-extended.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-low reset (0 = in reset)
//   req         access request, sampled only in IDLE
//   we          1 = store, 0 = load
//   addr        byte address
//   wdata       store data, right-aligned
//   size        00 byte, 01 half, 10 word, 11 illegal
//   ld_unsigned 1 = zero-extend loads, 0 = sign-extend
//   rdata       registered response data, held until the next response
//   ready       one-cycle response strobe
//   err         access rejected; only ever high together with ready
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               accept, commit;

  logic               req_we, req_unsigned;
  logic [31:0]        req_addr, req_wdata;
  logic [1:0]         req_size;

  logic               a_we, a_unsigned, a_err;
  logic [31:0]        a_addr, a_wdata;
  logic [1:0]         a_size;
  logic [ADDR_WIDTH-1:0] a_idx;
  logic [DATA_W-1:0]  old_word, shifted, merged, lane_data, load_val, resp_data;
  logic [3:0]         lane_mask;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Next-state logic; commit marks the edge that enters RESP (array access edge)
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_W'(WAIT_STATES);
          end
        end
      end
      BUSY: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_next = RESP;
          commit     = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Access datapath. With zero wait states the commit edge is also the
  // acceptance edge, so the live inputs stand in for the request registers.
  always_comb begin
    if (state == IDLE) begin
      a_we       = we;
      a_addr     = addr;
      a_wdata    = wdata;
      a_size     = size;
      a_unsigned = ld_unsigned;
    end else begin
      a_we       = req_we;
      a_addr     = req_addr;
      a_wdata    = req_wdata;
      a_size     = req_size;
      a_unsigned = req_unsigned;
    end

    a_idx = a_addr[ADDR_WIDTH+1:2];
    a_err = (a_size == 2'b11)
          | ((a_size == 2'b01) & a_addr[0])
          | ((a_size == 2'b10) & (a_addr[1:0] != 2'b00))
          | (a_addr[31:ADDR_WIDTH+2] != '0);

    old_word = mem[a_idx];
    shifted  = old_word >> {a_addr[1:0], 3'b000};

    case (a_size)
      2'b00: begin
        lane_mask = 4'(4'b0001 << a_addr[1:0]);
        lane_data = {4{a_wdata[7:0]}};
        load_val  = {{24{~a_unsigned & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        lane_mask = a_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{a_wdata[15:0]}};
        load_val  = {{16{~a_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = a_wdata;
        load_val  = old_word;
      end
    endcase

    // Read-modify-write merge: untouched lanes keep the stored value
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = lane_mask[i] ? lane_data[8*i +: 8] : old_word[8*i +: 8];
    end

    if (a_err)     resp_data = '0;
    else if (a_we) resp_data = merged;
    else           resp_data = load_val;
  end

  // State, counter, request capture and registered response
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ready        <= 1'b0;
      err          <= 1'b0;
      rdata        <= '0;
      req_we       <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_size     <= '0;
      req_unsigned <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ready <= commit;
      err   <= commit & a_err;
      if (commit) rdata <= resp_data;
      if (accept) begin
        req_we       <= we;
        req_addr     <= addr;
        req_wdata    <= wdata;
        req_size     <= size;
        req_unsigned <= ld_unsigned;
      end
    end
  end

  // Array is never cleared; a store only lands on a commit edge outside reset
  always_ff @(posedge clk) begin
    if (reset && commit && a_we && !a_err) mem[a_idx] <= merged;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (WAIT_STATES 0, 1, 3)
// share the request payload and reset; each has its own req line.
module tb_mem_responder;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        lu;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic        req0, req1, req3;
  logic [31:0] rdata0, rdata1, rdata3;
  logic        ready0, ready1, ready3;
  logic        err0, err1, err3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .ld_unsigned(ld_unsigned), .rdata(rdata0), .ready(ready0), .err(err0));

  mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .req(req1), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .ld_unsigned(ld_unsigned), .rdata(rdata1), .ready(ready1), .err(err1));

  mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .req(req3), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .ld_unsigned(ld_unsigned), .rdata(rdata3), .ready(ready3), .err(err3));

  function automatic op_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input logic lu,
                             input logic [31:0] exp_rd, input logic exp_e);
    op_t o;
    o.we = w; o.addr = a; o.wdata = d; o.size = sz; o.lu = lu;
    o.exp_rdata = exp_rd; o.exp_err = exp_e;
    return o;
  endfunction

  function automatic logic get_ready(input int d);
    case (d)
      0:       return ready0;
      1:       return ready1;
      default: return ready3;
    endcase
  endfunction

  function automatic logic get_err(input int d);
    case (d)
      0:       return err0;
      1:       return err1;
      default: return err3;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(input int d);
    case (d)
      0:       return rdata0;
      1:       return rdata1;
      default: return rdata3;
    endcase
  endfunction

  task automatic set_req(input int d, input logic v);
    case (d)
      0:       req0 = v;
      1:       req1 = v;
      default: req3 = v;
    endcase
  endtask

  // One handshake on instance d; payload is scrambled after acceptance.
  // lat = edges after acceptance until ready is seen (-1 on timeout).
  task automatic access(input int d, input op_t op, output logic [31:0] rd,
                        output logic e, output int lat, output logic pulse_ok);
    lat = -1; rd = '0; e = 1'b0; pulse_ok = 1'b0;
    @(negedge clk);
    we = op.we; addr = op.addr; wdata = op.wdata; size = op.size; ld_unsigned = op.lu;
    set_req(d, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_req(d, 1'b0);
    we = ~op.we; addr = op.addr ^ 32'h0000_0FFC; wdata = ~op.wdata;
    size = ~op.size; ld_unsigned = ~op.lu;
    for (int i = 0; i < 20; i++) begin
      if (get_ready(d)) begin
        lat = i; rd = get_rdata(d); e = get_err(d);
        break;
      end
      @(negedge clk);
    end
    if (lat >= 0) begin
      @(negedge clk);
      pulse_ok = !get_ready(d) && !get_err(d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; req3 = 1'b1;
    we = 1'b1; addr = 32'h30; wdata = 32'hFFFF_FFFF; size = 2'b10; ld_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      if (d == 2) continue;
      n_checks++;
      if (get_ready(d) !== 1'b0 || get_err(d) !== 1'b0 || get_rdata(d) !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs ws%0d: got ready=%b err=%b rdata=%h, expected 0/0/0",
                 d, get_ready(d), get_err(d), get_rdata(d));
      end
    end
    req1 = 1'b0; req3 = 1'b0; we = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ready0 !== 1'b1 || err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL first_accept_after_reset: got ready=%b err=%b, expected 1/0", ready0, err0);
    end
    req0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_reset_pulse: got %b, expected 0", ready0);
    end
  endtask

  // Runs a table of accesses on the WAIT_STATES=1 instance
  task automatic test_table(input string name, input op_t ops[$]);
    logic [31:0] rd;
    logic        e, pok;
    int          lat;
    foreach (ops[i]) begin
      access(1, ops[i], rd, e, lat, pok);
      n_checks++;
      if (lat !== 1) begin
        n_fail++;
        $display("FAIL %s[%0d] latency: got %0d, expected 1", name, i, lat);
      end
      n_checks++;
      if (e !== ops[i].exp_err) begin
        n_fail++;
        $display("FAIL %s[%0d] err: got %b, expected %b", name, i, e, ops[i].exp_err);
      end
      n_checks++;
      if (rd !== ops[i].exp_rdata) begin
        n_fail++;
        $display("FAIL %s[%0d] rdata: got %h, expected %h", name, i, rd, ops[i].exp_rdata);
      end
      n_checks++;
      if (pok !== 1'b1) begin
        n_fail++;
        $display("FAIL %s[%0d] pulse: got ready/err still high after one cycle, expected low", name, i);
      end
    end
  endtask

  task automatic test_store_load();
    op_t ops[$];
    ops.push_back(mk(1, 32'h10, 32'hDEAD_BEEF, 2'b10, 0, 32'hDEAD_BEEF, 0));
    ops.push_back(mk(0, 32'h10, 32'h0,         2'b10, 0, 32'hDEAD_BEEF, 0));
    test_table("store_load", ops);
  endtask

  task automatic test_byte();
    op_t ops[$];
    ops.push_back(mk(1, 32'h20, 32'h1122_3344, 2'b10, 0, 32'h1122_3344, 0));
    ops.push_back(mk(1, 32'h21, 32'h1234_56AA, 2'b00, 0, 32'h1122_AA44, 0));
    ops.push_back(mk(0, 32'h20, 32'h0,         2'b10, 0, 32'h1122_AA44, 0));
    ops.push_back(mk(0, 32'h21, 32'h0,         2'b00, 0, 32'hFFFF_FFAA, 0));
    ops.push_back(mk(0, 32'h21, 32'h0,         2'b00, 1, 32'h0000_00AA, 0));
    ops.push_back(mk(0, 32'h23, 32'h0,         2'b00, 0, 32'h0000_0011, 0));
    test_table("byte", ops);
  endtask

  task automatic test_half();
    op_t ops[$];
    ops.push_back(mk(1, 32'h20, 32'h0,         2'b10, 0, 32'h0000_0000, 0));
    ops.push_back(mk(1, 32'h22, 32'hABCD_8001, 2'b01, 0, 32'h8001_0000, 0));
    ops.push_back(mk(0, 32'h22, 32'h0,         2'b01, 0, 32'hFFFF_8001, 0));
    ops.push_back(mk(0, 32'h22, 32'h0,         2'b01, 1, 32'h0000_8001, 0));
    ops.push_back(mk(0, 32'h20, 32'h0,         2'b10, 0, 32'h8001_0000, 0));
    ops.push_back(mk(0, 32'h23, 32'h0,         2'b00, 0, 32'hFFFF_FF80, 0));
    ops.push_back(mk(1, 32'h20, 32'h0000_7FFF, 2'b01, 0, 32'h8001_7FFF, 0));
    ops.push_back(mk(0, 32'h20, 32'h0,         2'b01, 0, 32'h0000_7FFF, 0));
    ops.push_back(mk(0, 32'h20, 32'h0,         2'b10, 1, 32'h8001_7FFF, 0));
    test_table("half", ops);
  endtask

  task automatic test_errors();
    op_t ops[$];
    ops.push_back(mk(0, 32'h13,   32'h0,         2'b10, 0, 32'h0,         1));
    ops.push_back(mk(1, 32'h04,   32'hCAFE_F00D, 2'b10, 0, 32'hCAFE_F00D, 0));
    ops.push_back(mk(1, 32'h05,   32'h0000_1234, 2'b01, 0, 32'h0,         1));
    ops.push_back(mk(0, 32'h04,   32'h0,         2'b10, 0, 32'hCAFE_F00D, 0));
    ops.push_back(mk(0, 32'h08,   32'h0,         2'b11, 0, 32'h0,         1));
    ops.push_back(mk(1, 32'h00,   32'h0102_0304, 2'b10, 0, 32'h0102_0304, 0));
    ops.push_back(mk(0, 32'h1000, 32'h0,         2'b10, 0, 32'h0,         1));
    ops.push_back(mk(1, 32'h1000, 32'hFFFF_FFFF, 2'b10, 0, 32'h0,         1));
    ops.push_back(mk(0, 32'h00,   32'h0,         2'b10, 0, 32'h0102_0304, 0));
    ops.push_back(mk(1, 32'hFFC,  32'h0000_0077, 2'b10, 0, 32'h0000_0077, 0));
    ops.push_back(mk(0, 32'hFFC,  32'h0,         2'b10, 0, 32'h0000_0077, 0));
    test_table("errors", ops);
  endtask

  // WAIT_STATES=0 with req held: ready alternates, RESP cycles never accept
  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        e, pok;
    int          lat, pulses;
    access(0, mk(1, 32'h100, 32'h0BAD_F00D, 2'b10, 0, 32'h0, 0), rd, e, lat, pok);
    n_checks++;
    if (lat !== 0 || rd !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL b2b_preload: got lat=%0d rdata=%h, expected 0 / 0badf00d", lat, rd);
    end
    @(negedge clk);
    we = 1'b0; addr = 32'h100; size = 2'b10; ld_unsigned = 1'b0; req0 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready0 !== ((i % 2) == 0)) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got %b, expected %b", i, ready0, (i % 2) == 0);
      end
      if (ready0 === 1'b1) begin
        pulses++;
        n_checks++;
        if (rdata0 !== 32'h0BAD_F00D || err0 !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_rdata[%0d]: got %h err=%b, expected 0badf00d err=0", i, rdata0, err0);
        end
      end
    end
    req0 = 1'b0;
    n_checks++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d accesses, expected 3", pulses);
    end
  endtask

  // WAIT_STATES=3: reset during BUSY discards the pending store
  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        e, pok, seen;
    int          lat;
    access(3, mk(1, 32'h40, 32'h5A5A_5A5A, 2'b10, 0, 32'h0, 0), rd, e, lat, pok);
    n_checks++;
    if (lat !== 3 || rd !== 32'h5A5A_5A5A || e !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_preload: got lat=%0d rdata=%h err=%b, expected 3 / 5a5a5a5a / 0", lat, rd, e);
    end
    @(negedge clk);
    we = 1'b1; addr = 32'h40; wdata = 32'h55; size = 2'b10; ld_unsigned = 1'b0; req3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req3 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_checks++;
    if (rdata3 !== 32'h0 || ready3 !== 1'b0 || err3 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got rdata=%h ready=%b err=%b, expected 0/0/0", rdata3, ready3, err3);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ready3 !== 1'b0 || err3 !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_ready: got a ready/err pulse after reset, expected none");
    end
    access(3, mk(0, 32'h40, 32'h0, 2'b10, 0, 32'h0, 0), rd, e, lat, pok);
    n_checks++;
    if (lat !== 3 || rd !== 32'h5A5A_5A5A || e !== 1'b0 || pok !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_old_contents: got lat=%0d rdata=%h err=%b pulse=%b, expected 3 / 5a5a5a5a / 0 / 1",
               lat, rd, e, pok);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle core's unified instruction/data memory port. The datapath drives a byte address and store data and consumes read data. This block answers each access with a request/ready handshake and a configurable number of wait states. It performs byte/half/word stores with lane merging and loads with sign or zero extension. It replaces the ideal zero-latency memory model, so the controller FSM can be verified against realistic memory timing.

## Interface
- ADDR_WIDTH, 10, word-address bits; array depth = 2^ADDR_WIDTH 32-bit words
- WAIT_STATES, 1, extra cycles between acceptance and response (0..15)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = in reset); sampled on rising clk
- req  in  1  access request; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- addr  in  32  byte address (core's Mem_WrAddr)
- wdata  in  32  store data, right-aligned (core's Mem_WrData)
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- ld_unsigned  in  1  1 = zero-extend loads (funct3[2]), 0 = sign-extend
- rdata  out  32  load result, registered, held until next response
- ready  out  1  one-cycle response strobe
- err  out  1  access rejected; valid only with ready

## Operation
- The memory array is not cleared by reset, and its contents survive reset.
- FSM states: IDLE, BUSY, RESP.
  - IDLE & req=1: capture we/addr/wdata/size/ld_unsigned into request registers (acceptance edge). Load counter with WAIT_STATES. Go to BUSY, or directly to RESP if WAIT_STATES=0.
  - BUSY: counter decrements each edge. On the edge where counter==1, go to RESP.
  - RESP: ready=1 for exactly one cycle, then IDLE unconditionally. req is not sampled in RESP.
- The array access happens on the edge entering RESP and uses only the captured request. Inputs may change freely after the acceptance edge.
- Error check on captured request; any of these sets err=1:
  - size=11
  - size=01 with addr[0]=1
  - size=10 with addr[1:0]!=0
  - addr[31:ADDR_WIDTH+2] != 0
- An errored access writes nothing and returns rdata=0.
- Word index = addr[ADDR_WIDTH+1:2].
- Stores (read-modify-write on the same edge):
  - Byte: lane addr[1:0] ← wdata[7:0].
  - Half: lanes {addr[1],1},{addr[1],0} ← wdata[15:0].
  - Word: whole word.
  - Untouched lanes keep their value.
  - rdata after a store = the merged word written.
- Loads: select lane(s) by addr[1:0], then extend to 32 bits.
  - Byte: bit 7 sign, or zero when ld_unsigned.
  - Half: bit 15 sign, or zero when ld_unsigned.
  - Word: unchanged, ld_unsigned ignored.

## Timing
- Reset values: state=IDLE, ready=0, err=0, rdata=0, counter=0.
- Latency: acceptance at edge k; ready high in the cycle following edge k+WAIT_STATES.
  - WAIT_STATES=0: response the cycle after acceptance.
  - Throughput: one access per WAIT_STATES+2 cycles.
- req held high continuously: a new access is accepted on the first edge after RESP (in IDLE). The requester deasserts req during RESP to avoid a duplicate access.
- ready/err only ever high together for one cycle. err=0 whenever ready=0.
- Reset low mid-access (BUSY or RESP entry edge): state→IDLE, ready/err/rdata→0. A store not yet committed is discarded. A store committed on an earlier edge persists.
- Reset low with req=1: nothing accepted. The first acceptance is on the first edge with reset=1.
- Back-to-back store then load of the same word returns the stored data (no bypass hazard, since the accesses are serialized).

## Test plan
- WAIT_STATES=1, sw 0xDEADBEEF @0x10, then lw @0x10 → ready exactly 2 cycles after each acceptance edge; rdata=0xDEADBEEF, err=0.
- Preload word 0x11223344 @0x20; sb 0xAA @0x21; lw @0x20 → 0x1122AA44. Then lb @0x21 → 0xFFFFFFAA, lbu @0x21 → 0x000000AA.
- sh 0x8001 @0x22 on 0x00000000; lh @0x22 → 0xFFFF8001; lhu @0x22 → 0x00008001; lw @0x20 → 0x80010000.
- Misaligned and illegal requests:
  - lw @0x13 → ready with err=1, rdata=0.
  - sh @0x05 → err=1, memory unchanged (verify by lw @0x04).
  - size=11 → err=1.
  - ADDR_WIDTH=10, addr 0x00001000 → err=1.
- WAIT_STATES=0, req held high for 6 cycles of loads → ready pulses every 2nd cycle, 3 accesses; no acceptance in RESP cycles.
- WAIT_STATES=3: sw 0x55 @0x40 accepted, reset low for one cycle during BUSY → ready never asserts, outputs 0. Subsequent lw @0x40 returns the old contents (store discarded).
